// File: rtl/oled_text_formatter_if.sv
// Character-write handshake between the text formatter (master) and the
// OLED character-buffer writer (slave).
//
// Handshake: the master raises char_valid with char_addr/char_data; a
// character transfers on every rising clk edge where char_valid and
// char_ready are both high. While char_valid is high and char_ready is low,
// the master holds char_addr/char_data stable. char_ready carries no meaning
// while char_valid is low.
interface oled_text_formatter_if #(
  parameter int ADDR_W = 6
);
  logic              char_valid;
  logic              char_ready;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;

  modport master (
    output char_valid,
    output char_addr,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_addr,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/oled_text_formatter.sv
// oled_text_formatter: renders the opcode text word and the result data word
// as one 16-column text line ("OPCD 0xHHHHHHHH ") and streams it, one
// character per handshake, into the OLED character buffer. A new frame is
// sent after reset and whenever either input word differs from the snapshot
// of the last rendered frame.
//
// Build option: define OLED_LEADING_ZERO_BLANK_EN to render leading zero
// nibbles of the data word (columns 7..13) as spaces. Column 14 always shows
// a digit. Frame length and timing are the same in both builds.
module oled_text_formatter #(
  parameter int LINE_BASE = 0,
  parameter int ADDR_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           OLED_data,
  input  logic [31:0]           OLED_opcode_disp,
  oled_text_formatter_if.master char_if,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_snap_op;
  logic [31:0] r_snap_data;
  logic [3:0]  r_col;
  logic        r_refresh_pending;
  logic        r_char_valid;
  logic        r_busy;
  logic        r_frame_done;

  state_t      w_state_nxt;
  logic [3:0]  w_col_nxt;
  logic        w_valid_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_pending_nxt;
  logic        w_capture;
  logic        w_change;

  logic [7:0]  w_char;
  logic [7:0]  w_byte;
  logic [2:0]  w_nib_idx;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [7:0]  w_lead_zero;

  // State, snapshot, column and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_snap_op         <= 32'h0;
      r_snap_data       <= 32'h0;
      r_col             <= 4'd0;
      r_refresh_pending <= 1'b1;
      r_char_valid      <= 1'b0;
      r_busy            <= 1'b0;
      r_frame_done      <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_col             <= w_col_nxt;
      r_refresh_pending <= w_pending_nxt;
      r_char_valid      <= w_valid_nxt;
      r_busy            <= w_busy_nxt;
      r_frame_done      <= w_done_nxt;
      if (w_capture) begin
        r_snap_op   <= OLED_opcode_disp;
        r_snap_data <= OLED_data;
      end
    end
  end

  // Next-state logic: start a frame on pending refresh or input change,
  // step columns on accepted characters, pulse frame_done after column 15.
  // DONE may start the next frame directly so frames are one cycle apart.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_valid_nxt   = r_char_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_pending_nxt = r_refresh_pending;
    w_capture     = 1'b0;
    w_change      = r_refresh_pending ||
                    (OLED_data != r_snap_data) ||
                    (OLED_opcode_disp != r_snap_op);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_change) begin
          w_capture     = 1'b1;
          w_pending_nxt = 1'b0;
          w_col_nxt     = 4'd0;
          w_valid_nxt   = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_SEND;
        end else begin
          w_valid_nxt   = 1'b0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      S_SEND: begin
        if (r_char_valid && char_if.char_ready) begin
          if (r_col != 4'd15) begin
            w_col_nxt = r_col + 4'd1;
          end else begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Leading-zero run over the data nibbles, most significant first:
  // bit k is set when nibbles 0..k are all zero.
`ifdef OLED_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_lead_zero[0] = (r_snap_data[31:28] == 4'h0);
    for (int k = 1; k < 8; k++) begin
      w_lead_zero[k] = w_lead_zero[k-1] && (r_snap_data[28-4*k +: 4] == 4'h0);
    end
  end
`else
  // Blanking disabled: no nibble is ever treated as a leading zero.
  always_comb begin
    w_lead_zero = 8'h00;
  end
`endif

  // Character for the current column, taken only from snapshot and column.
  always_comb begin
    w_byte    = 8'h00;
    w_nib_idx = 3'(r_col - 4'd7);
    w_nib     = r_snap_data[{3'd7 - w_nib_idx, 2'b00} +: 4];
    w_blank   = (w_nib_idx != 3'd7) && w_lead_zero[w_nib_idx];
    w_char    = 8'h20;
    case (r_col)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        case (r_col[1:0])
          2'd0:    w_byte = r_snap_op[31:24];
          2'd1:    w_byte = r_snap_op[23:16];
          2'd2:    w_byte = r_snap_op[15:8];
          default: w_byte = r_snap_op[7:0];
        endcase
        w_char = (w_byte == 8'h00) ? 8'h20 : w_byte;
      end
      4'd5: w_char = 8'h30;
      4'd6: w_char = 8'h78;
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
        if (w_blank) begin
          w_char = 8'h20;
        end else if (w_nib < 4'd10) begin
          w_char = 8'h30 + {4'h0, w_nib};
        end else begin
          w_char = 8'h37 + {4'h0, w_nib};
        end
      end
      default: w_char = 8'h20;
    endcase
  end

  assign char_if.char_valid = r_char_valid;
  assign char_if.char_addr  = ADDR_W'(LINE_BASE) + ADDR_W'(r_col);
  assign char_if.char_data  = w_char;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;
  assign o_state_dbg        = r_state;

endmodule
